// File: rtl/spi_flash_read_ctrl_pkg.sv
// Shared definitions for the SPI flash read controller: FSM encoding,
// default flash command/address bytes and FIFO geometry.
package spi_flash_read_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        READ = 3'b010,
        SEND = 3'b100
    } state_t;

    localparam logic [7:0] DEF_READ_CMD    = 8'h03;
    localparam logic [7:0] DEF_SECTOR_ADDR = 8'h00;
    localparam logic [7:0] DEF_PAGE_ADDR   = 8'h04;
    localparam logic [7:0] DEF_BYTE_ADDR   = 8'h25;

    localparam int unsigned FIFO_DEPTH = 128;
    localparam int unsigned FIFO_AW    = 7;

    // Header byte shifted out in slot idx of the READ sequence.
    function automatic logic [7:0] header_byte(
        input logic [1:0] idx,
        input logic [7:0] cmd,
        input logic [7:0] sector,
        input logic [7:0] page,
        input logic [7:0] byte_a
    );
        case (idx)
            2'd0:    return cmd;
            2'd1:    return sector;
            2'd2:    return page;
            default: return byte_a;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_read_ctrl_if.sv
// SPI flash pins plus the pi_data/pi_flag replay strobe of the read controller.
interface spi_flash_read_ctrl_if;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [7:0] pi_data;
    logic       pi_flag;

    modport master (output cs_n, output sck, output mosi, input miso,
                    output pi_data, output pi_flag);
    modport slave  (input cs_n, input sck, input mosi, output miso,
                    input pi_data, input pi_flag);
endinterface

// File: rtl/spi_flash_read_ctrl_read_fifo.sv
// Synchronous 8-bit x 128 FIFO with registered, one-cycle-latency read data.
module read_fifo
    import spi_flash_read_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty
);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_wr;
    logic               do_rd;

    assign empty = (count == '0);
    assign do_wr = wr_en && (count != FULL_CNT);
    assign do_rd = rd_en && !empty;

    // Storage carries no reset so it can map onto block RAM; the
    // pointers alone define the FIFO contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_rd) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
                dout   <= mem[rd_ptr];
            end
            if (do_wr && !do_rd)      count <= count + (FIFO_AW + 1)'(1);
            else if (!do_wr && do_rd) count <= count - (FIFO_AW + 1)'(1);
        end
    end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// Reads DATA_NUM bytes from an SPI NOR flash (READ 0x03, mode 0) on a key
// press, buffers them, then replays them as paced pi_data/pi_flag strobes.
module spi_flash_read_ctrl
    import spi_flash_read_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX    = 60_000,
    parameter int unsigned DATA_NUM    = 100,
    parameter logic [7:0]  READ_CMD    = DEF_READ_CMD,
    parameter logic [7:0]  SECTOR_ADDR = DEF_SECTOR_ADDR,
    parameter logic [7:0]  PAGE_ADDR   = DEF_PAGE_ADDR,
    parameter logic [7:0]  BYTE_ADDR   = DEF_BYTE_ADDR
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  key_flag,
    spi_flash_read_ctrl_if.master bus
);
    localparam int unsigned BYTE_W = $clog2(DATA_NUM + 4);
    localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(DATA_NUM + 3);
    localparam logic [BYTE_W-1:0] FIRST_DATA = BYTE_W'(4);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);

    state_t state;
    state_t next_state;

    logic [1:0]        phase_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        rx_byte;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic              rd_dly;

    logic              cs_n;
    logic              sck;
    logic              mosi;
    logic [7:0]        pi_data;
    logic              pi_flag;

    logic              bit_done;
    logic              read_last;
    logic [2:0]        nxt_bit;
    logic [BYTE_W-1:0] nxt_byte;
    logic [7:0]        hdr;
    logic              nxt_mosi;

    assign bus.cs_n    = cs_n;
    assign bus.sck     = sck;
    assign bus.mosi    = mosi;
    assign bus.pi_data = pi_data;
    assign bus.pi_flag = pi_flag;

    always_comb begin
        bit_done  = (state == READ) && (phase_cnt == 2'd3);
        read_last = bit_done && (bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE);
        nxt_bit   = bit_cnt + 3'd1;
        nxt_byte  = (bit_cnt == 3'd7) ? byte_cnt + BYTE_W'(1) : byte_cnt;
        hdr       = header_byte(nxt_byte[1:0], READ_CMD, SECTOR_ADDR, PAGE_ADDR, BYTE_ADDR);
        nxt_mosi  = (nxt_byte < FIRST_DATA) ? hdr[~nxt_bit] : 1'b0;
        fifo_rd   = (state == SEND) && (wait_cnt == WAIT_LAST) && !fifo_empty;

        next_state = state;
        unique case (state)
            IDLE:    if (key_flag) next_state = READ;
            READ:    if (read_last) next_state = SEND;
            // Leave once the final strobe is on the outputs and nothing remains.
            SEND:    if (fifo_empty && pi_flag) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            pi_data   <= '0;
            pi_flag   <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            wait_cnt  <= '0;
            rx_byte   <= '0;
            fifo_wr   <= 1'b0;
            rd_dly    <= 1'b0;
        end else begin
            fifo_wr <= 1'b0;
            rd_dly  <= fifo_rd;
            pi_flag <= rd_dly;
            if (rd_dly) pi_data <= fifo_dout;

            unique case (state)
                IDLE: begin
                    if (key_flag) begin
                        cs_n      <= 1'b0;
                        mosi      <= READ_CMD[7];
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                    end
                end
                READ: begin
                    phase_cnt <= phase_cnt + 2'd1;
                    if (phase_cnt == 2'd1) sck <= 1'b1;
                    // First sys_clk with sck high: sample miso.
                    if (phase_cnt == 2'd2) begin
                        rx_byte <= {rx_byte[6:0], bus.miso};
                        if (bit_cnt == 3'd7 && byte_cnt >= FIRST_DATA) fifo_wr <= 1'b1;
                    end
                    if (bit_done) begin
                        sck <= 1'b0;
                        if (read_last) begin
                            cs_n     <= 1'b1;
                            mosi     <= 1'b0;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            bit_cnt  <= nxt_bit;
                            byte_cnt <= nxt_byte;
                            mosi     <= nxt_mosi;
                        end
                    end
                end
                SEND: begin
                    if (next_state == IDLE || wait_cnt == WAIT_LAST) wait_cnt <= '0;
                    else                                             wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    read_fifo u_read_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .wr_en (fifo_wr),
        .din   (rx_byte),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: behavioural M25P16-style flash returning
// mem[a] = a[7:0], plus a scoreboard of the expected replayed byte stream.
module tb_spi_flash_read_ctrl;

    localparam int unsigned WAIT_MAX = 100;
    localparam int unsigned DATA_NUM = 100;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_flag;

    spi_flash_read_ctrl_if bus();

    spi_flash_read_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .DATA_NUM (DATA_NUM)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_flag  (key_flag),
        .bus       (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Flash model state
    logic [31:0] cmd_word;
    int unsigned rx_bits;
    int unsigned out_bit;
    int unsigned out_byte;
    int unsigned sck_rises;
    logic [7:0]  exp_q[$];

    initial begin : flash_model
        logic [7:0] db;
        bus.miso = 1'b0;
        forever begin
            @(negedge bus.cs_n);
            cmd_word  = '0;
            rx_bits   = 0;
            out_bit   = 0;
            out_byte  = 0;
            sck_rises = 0;
            if (sys_rst_n === 1'b1)
                for (int k = 0; k < DATA_NUM; k++) exp_q.push_back(8'(8'h25 + k));
            while (bus.cs_n === 1'b0) begin
                @(bus.sck or posedge bus.cs_n);
                if (bus.cs_n !== 1'b0) break;
                if (bus.sck) begin
                    sck_rises++;
                    if (rx_bits < 32) begin
                        cmd_word = {cmd_word[30:0], bus.mosi};
                        rx_bits++;
                    end
                end else if (rx_bits == 32) begin
                    db = cmd_word[7:0] + 8'(out_byte);
                    bus.miso = db[7 - out_bit];
                    out_bit++;
                    if (out_bit == 8) begin
                        out_bit = 0;
                        out_byte++;
                    end
                end
            end
            if (sys_rst_n !== 1'b1) exp_q.delete();
        end
    end

    // Per-cycle compare process
    int unsigned cyc = 0;
    int unsigned low_cnt = 0;
    int unsigned cs_falls = 0;
    int unsigned send_start = 0;
    int unsigned prev_strobe = 0;
    int unsigned strobe_run = 0;
    int unsigned total_strobes = 0;
    logic        prev_cs = 1'b1;

    always @(negedge sys_clk) begin
        logic [7:0] exp_b;
        cyc++;
        if (sys_rst_n === 1'b1) begin
            if (bus.cs_n === 1'b0) begin
                if (prev_cs) begin
                    low_cnt    = 0;
                    strobe_run = 0;
                    cs_falls++;
                end
                low_cnt++;
            end else if (!prev_cs) begin
                send_start = cyc;
            end
            if (bus.pi_flag === 1'b1) begin
                total_strobes++;
                if (exp_q.size() == 0) chk("unexpected_strobe", 32'(bus.pi_flag), 0);
                else begin
                    exp_b = exp_q.pop_front();
                    chk("pi_data", 32'(bus.pi_data), 32'(exp_b));
                end
                if (strobe_run == 0) chk("first_strobe_delay", cyc - send_start, WAIT_MAX + 1);
                else                 chk("strobe_spacing", cyc - prev_strobe, WAIT_MAX);
                prev_strobe = cyc;
                strobe_run++;
            end
        end
        prev_cs = bus.cs_n;
    end

    task automatic start_read();
        @(negedge sys_clk);
        key_flag = 1'b1;
        @(negedge sys_clk);
        key_flag = 1'b0;
        chk("cs_n_fall", 32'(bus.cs_n), 0);
    endtask

    task automatic wait_cs_high(input int unsigned bound);
        int unsigned n = 0;
        while (bus.cs_n !== 1'b1 && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        #1;
        chk("cs_n_rise_timeout", 32'(bus.cs_n), 1);
    endtask

    task automatic check_read_done();
        chk("cs_low_clocks", low_cnt, 3328);
        chk("sck_rises", sck_rises, 832);
        chk("cmd_addr", cmd_word, 32'h0300_0425);
        chk("mosi_idle", 32'(bus.mosi), 0);
        chk("sck_idle", 32'(bus.sck), 0);
    endtask

    task automatic wait_last_strobe(input int unsigned bound);
        int unsigned n = 0;
        while (strobe_run != DATA_NUM && n < bound) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk("strobe_count", strobe_run, DATA_NUM);
    endtask

    initial begin : watchdog
        #2_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned hi;
        int unsigned lo;
        int unsigned n;
        int unsigned f0;
        int unsigned s0;

        sys_rst_n = 1'b0;
        key_flag  = 1'b0;
        #30;
        chk("rst_cs_n", 32'(bus.cs_n), 1);
        chk("rst_sck", 32'(bus.sck), 0);
        chk("rst_mosi", 32'(bus.mosi), 0);
        chk("rst_pi_flag", 32'(bus.pi_flag), 0);
        chk("rst_pi_data", 32'(bus.pi_data), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (48) @(negedge sys_clk);

        // Run A: full read with key presses during READ, SEND and at exit
        start_read();
        n = 0;
        while (!bus.sck && n < 8) begin @(negedge sys_clk); n++; end
        hi = 0;
        while (bus.sck && hi < 8) begin @(negedge sys_clk); hi++; end
        lo = 0;
        while (!bus.sck && lo < 8) begin @(negedge sys_clk); lo++; end
        chk("sck_high_clocks", hi, 2);
        chk("sck_period_clocks", hi + lo, 4);

        repeat (1000) @(negedge sys_clk);
        key_flag = 1'b1;
        @(negedge sys_clk);
        key_flag = 1'b0;
        wait_cs_high(4000);
        check_read_done();

        repeat (2000) @(negedge sys_clk);
        key_flag = 1'b1;
        @(negedge sys_clk);
        key_flag = 1'b0;
        #1;
        chk("key_in_send_cs_n", 32'(bus.cs_n), 1);

        wait_last_strobe(11000);
        key_flag = 1'b1;
        @(negedge sys_clk);
        key_flag = 1'b0;
        f0 = cs_falls;
        repeat (40) @(negedge sys_clk);
        #1;
        chk("key_at_exit_ignored", cs_falls, f0);
        chk("pi_data_hold", 32'(bus.pi_data), 32'h88);
        chk("queue_drained_a", exp_q.size(), 0);
        chk("total_strobes_a", total_strobes, 100);

        // Run B: back in IDLE, then reset during byte 10
        start_read();
        repeat (10 * 32) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(bus.cs_n), 1);
        chk("abort_sck", 32'(bus.sck), 0);
        chk("abort_pi_data", 32'(bus.pi_data), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        s0 = total_strobes;
        repeat (300) @(negedge sys_clk);
        #1;
        chk("abort_no_strobe", total_strobes, s0);
        chk("abort_cs_stays_high", 32'(bus.cs_n), 1);

        // Run C: clean full read after the abort
        start_read();
        wait_cs_high(4000);
        check_read_done();
        wait_last_strobe(11000);
        repeat (200) @(negedge sys_clk);
        #1;
        chk("queue_drained_c", exp_q.size(), 0);
        chk("total_strobes_c", total_strobes, 200);
        chk("pi_data_hold_c", 32'(bus.pi_data), 32'h88);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
